code_sender: RTL

CODE_SENDER -- requirements
Module: code_sender

---
 rtl/code_sender.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/code_sender.sv
// Serial code transmitter for a combination lock: sends a latched code MSB-first,
// retries on failure up to MAX_TRY attempts, then locks out until reset.
module code_sender #(
    parameter int WIDTH   = 8,
    parameter int MAX_TRY = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] code_word,
    input  logic [3:0]       code_len,
    input  logic             openlock,
    input  logic             alarm,
    output logic             code,
    output logic             busy,
    output logic             done,
    output logic             granted,
    output logic [1:0]       tries,
    output logic             locked_out
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND    = 2'd1,
        FINISH  = 2'd2,
        LOCKOUT = 2'd3
    } state_t;

    localparam logic [3:0] LEN_MAX   = (WIDTH > 15) ? 4'd15 : 4'(WIDTH);
    localparam logic [1:0] TRY_LIMIT = 2'(MAX_TRY);

    function automatic logic [3:0] clamp_len(input logic [3:0] len);
        return (len > LEN_MAX) ? LEN_MAX : len;
    endfunction

    // Index lookup that tolerates any index width and returns 0 out of range.
    function automatic logic bit_at(input logic [WIDTH-1:0] word, input logic [3:0] idx);
        logic b;
        b = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (i == int'(idx)) b = word[i];
        end
        return b;
    endfunction

    state_t           state_q;
    logic [WIDTH-1:0] word_q;
    logic [3:0]       len_q;
    logic [3:0]       idx_q;
    logic             code_q;
    logic             busy_q;
    logic             done_q;
    logic             granted_q;
    logic [1:0]       tries_q;
    logic             locked_q;

    logic [3:0] len_d;
    logic       accept_d;
    logic       first_new_d;
    logic       first_lat_d;
    logic       next_bit_d;
    logic [1:0] tries_d;
    logic       grant_d;
    logic       fail_d;

    always_comb begin
        len_d       = clamp_len(code_len);
        accept_d    = (state_q == IDLE) && start && (code_len != 4'd0);
        first_new_d = bit_at(code_word, len_d - 4'd1);
        first_lat_d = bit_at(word_q, len_q - 4'd1);
        next_bit_d  = bit_at(word_q, idx_q - 4'd1);
        tries_d     = (tries_q == TRY_LIMIT) ? tries_q : tries_q + 2'd1;
        grant_d     = openlock && !alarm;
        fail_d      = alarm || (!openlock && (idx_q == 4'd0));
    end

    // Request payload is captured only on acceptance, so it cannot change mid-request.
    always_ff @(posedge clk) begin
        if (accept_d) begin
            word_q <= code_word;
            len_q  <= len_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            idx_q     <= 4'd0;
            code_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            granted_q <= 1'b0;
            tries_q   <= 2'd0;
            locked_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    code_q <= 1'b0;
                    busy_q <= 1'b0;
                    if (accept_d) begin
                        idx_q     <= len_d - 4'd1;
                        code_q    <= first_new_d;
                        busy_q    <= 1'b1;
                        tries_q   <= 2'd0;
                        granted_q <= 1'b0;
                        state_q   <= SEND;
                    end
                end
                SEND: begin
                    if (grant_d) begin
                        granted_q <= 1'b1;
                        done_q    <= 1'b1;
                        busy_q    <= 1'b0;
                        code_q    <= 1'b0;
                        state_q   <= FINISH;
                    end else if (fail_d) begin
                        tries_q <= tries_d;
                        if (tries_d == TRY_LIMIT) begin
                            locked_q  <= 1'b1;
                            done_q    <= 1'b1;
                            busy_q    <= 1'b0;
                            code_q    <= 1'b0;
                            granted_q <= 1'b0;
                            state_q   <= LOCKOUT;
                        end else begin
                            // Retry starts on the very next cycle with the first bit again.
                            idx_q  <= len_q - 4'd1;
                            code_q <= first_lat_d;
                        end
                    end else begin
                        idx_q  <= idx_q - 4'd1;
                        code_q <= next_bit_d;
                    end
                end
                FINISH: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                LOCKOUT: begin
                    done_q   <= 1'b0;
                    code_q   <= 1'b0;
                    busy_q   <= 1'b0;
                    locked_q <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign code       = code_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign granted    = granted_q;
    assign tries      = tries_q;
    assign locked_out = locked_q;

endmodule
